regfile_mmio: RTL and testbench
===============================

# regfile_mmio

Parametrised processor register file with two combinational read ports and one synchronous write port. A configurable window of registers is memory-mapped to board inputs: synchronised switch bytes, button levels, and sticky button-press events that software clears by writing to them. It replaces the fixed-width, fixed-mapping register file in the processor datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data-port width
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- SW_WIDTH, 16, switch input width; must be a multiple of 8
- BTN_WIDTH, 4, button input width; must be ≤ DATA_WIDTH
- IO_BASE, 26, first mapped register; IO_BASE + SW_WIDTH/8 + 1 must be < NUM_REGS and IO_BASE ≥ 1

Ports:
- clock  in  1  rising-edge clock
- ctrl_reset_n  in  1  asynchronous reset, active low
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  ADDR_WIDTH  write address
- ctrl_readRegA  in  ADDR_WIDTH  read address A
- ctrl_readRegB  in  ADDR_WIDTH  read address B
- data_writeReg  in  DATA_WIDTH  write data
- data_readRegA  out  DATA_WIDTH  read data A, combinational
- data_readRegB  out  DATA_WIDTH  read data B, combinational
- SW  in  SW_WIDTH  asynchronous switch inputs
- BTN  in  BTN_WIDTH  asynchronous button inputs
- reg_sw  out  SW_WIDTH  synchronised switch value
- reg_btn_event  out  BTN_WIDTH  sticky event bits

## Operation
Register map, with S = SW_WIDTH/8:
- Register 0 always reads 0. Writes to it are ignored.
- Registers IO_BASE .. IO_BASE+S-1 are switch byte k = SW[8k+7:8k], zero-extended. Read-only.
- Register IO_BASE+S is the button level, zero-extended. Read-only.
- Register IO_BASE+S+1 is the button event register, zero-extended. It is write-1-to-clear.
- All other registers are general purpose (GP). A GP register loads data_writeReg on the rising edge when ctrl_writeEnable=1 and the address matches.

Writes to read-only mapped registers are ignored.

Input path:
- SW and BTN each pass through a two-flop synchroniser (stage1, stage2).
- Switch and level registers present the stage2 value directly.
- A third BTN flop (stage3) provides edge detection.

Event register:
- Bit i sets when stage2[i]=1 and stage3[i]=0 (rising edge).
- A write to the event register clears every bit i where data_writeReg[i]=1.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- Bits at or above BTN_WIDTH read 0.

Reads:
- Out-of-map behaviour is not applicable: every address decodes.
- Port A and port B are independent and may select the same register.

## Timing
- Reset (ctrl_reset_n=0, asynchronous): all GP registers, synchroniser stages, and event bits clear to 0. Consequently data_readRegA, data_readRegB, reg_sw and reg_btn_event all read 0 for every address while reset is asserted.
- Reset deassertion is sampled at the next rising edge.
- Write latency: a GP write is visible on the read ports after the rising edge that commits it.
- Switch and button input latency: a change is visible after 2 rising edges.
- Event latency: a BTN rising edge sets the event bit after 3 rising edges. A held button produces one event only.
- A button pulse shorter than one clock may be missed. This is accepted.
- Reset asserted mid-operation discards any pending write and any event set in that cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read of a GP register whose address equals ctrl_writeReg while ctrl_writeEnable=1 returns data_writeReg in the same cycle. Register 0 and mapped registers are never bypassed.
- REGFILE_BYPASS_EN undefined: same-cycle reads return the old register value.

## Test plan
- Reset state: hold ctrl_reset_n=0 with SW=16'hFFFF and BTN=4'hF. Both read ports return 0 at every address, including IO_BASE..IO_BASE+3.
- GP writes: write 32'hDEADBEEF to r5 and 32'h1234 to r0. Then r5 reads DEADBEEF, r0 reads 0, and a write to r26 leaves it at the switch value.
- Switch mapping: drive SW=16'hA55A. After 2 edges, r26=32'h5A, r27=32'hA5, reg_sw=16'hA55A. One edge after the change, the old value is still read.
- Button event: pulse BTN[1] for 5 cycles. r28 bit1 follows the level, r29=32'h2 and stays set after release. Writing 32'h2 to r29 clears it to 0.
- Event collision: write 32'hF to r29 on the same edge an event on BTN[0] is detected. r29=32'h1 afterwards.
- Bypass: write 32'h55 to r7 while reading r7 on port A. With REGFILE_BYPASS_EN, port A shows 32'h55 that cycle; without it, port A shows the previous value.

Source files
------------

// File: rtl/regfile_mmio_if.sv
// Register-file access bus for regfile_mmio: one write port and two read ports.
// The write strobe carries no handshake. The register file always accepts it. Reads are combinational.
interface regfile_mmio_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/regfile_mmio.sv
// Register file with memory-mapped switch bytes, button levels and sticky write-1-to-clear button events.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle GP writes to the read ports.
module regfile_mmio #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SW_WIDTH   = 16,
  parameter int BTN_WIDTH  = 4,
  parameter int IO_BASE    = 26
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  regfile_mmio_if.slave        bus,
  input  logic [SW_WIDTH-1:0]  SW,
  input  logic [BTN_WIDTH-1:0] BTN,
  output logic [SW_WIDTH-1:0]  reg_sw,
  output logic [BTN_WIDTH-1:0] reg_btn_event
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int S        = SW_WIDTH / 8;
  localparam int BTN_ADDR = IO_BASE + S;
  localparam int EV_ADDR  = IO_BASE + S + 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [SW_WIDTH-1:0]   sw_s1, sw_s2;
  logic [BTN_WIDTH-1:0]  btn_s1, btn_s2, btn_s3;
  logic [BTN_WIDTH-1:0]  ev;
  logic [BTN_WIDTH-1:0]  ev_rise;
  logic [BTN_WIDTH-1:0]  ev_clr;
  logic                  wr_gp;

  function automatic logic is_gp(input logic [ADDR_WIDTH-1:0] a);
    int ai;
    ai = int'(a);
    return (ai != 0) && ((ai < IO_BASE) || (ai > EV_ADDR));
  endfunction

  assign wr_gp   = bus.ctrl_writeEnable && is_gp(bus.ctrl_writeReg);
  assign ev_rise = btn_s2 & ~btn_s3;
  assign ev_clr  = (bus.ctrl_writeEnable && (int'(bus.ctrl_writeReg) == EV_ADDR))
                   ? bus.data_writeReg[BTN_WIDTH-1:0] : '0;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      btn_s1 <= BTN;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  // Set is OR-ed in after the clear so a simultaneous edge always survives.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) ev <= '0;
    else               ev <= (ev & ~ev_clr) | ev_rise;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_gp) begin
      regs[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    int ai;
    v  = '0;
    ai = int'(a);
    if (is_gp(a)) begin
      v = regs[a];
`ifdef REGFILE_BYPASS_EN
      // Only GP addresses reach here, so register 0 and mapped registers are never forwarded.
      if (ctrl_reset_n && bus.ctrl_writeEnable && (bus.ctrl_writeReg == a)) v = bus.data_writeReg;
`endif
    end else if (ai == BTN_ADDR) begin
      v[BTN_WIDTH-1:0] = btn_s2;
    end else if (ai == EV_ADDR) begin
      v[BTN_WIDTH-1:0] = ev;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (ai == IO_BASE + k) v[7:0] = sw_s2[8*k +: 8];
      end
    end
    return v;
  endfunction

  always_comb begin
    bus.data_readRegA = read_reg(bus.ctrl_readRegA);
    bus.data_readRegB = read_reg(bus.ctrl_readRegB);
  end

  assign reg_sw        = sw_s2;
  assign reg_btn_event = ev;
endmodule

// File: tb/tb_regfile_mmio.sv
// Directed bench for regfile_mmio. Drivers queue expected values, and a negedge monitor compares them.
// Build with REGFILE_BYPASS_EN defined to check the forwarding variant.
module tb_regfile_mmio;
  localparam int DW = 32;
  localparam int AW = 5;

  logic        clock;
  logic        ctrl_reset_n;
  logic [15:0] sw;
  logic [3:0]  btn;
  logic [15:0] reg_sw;
  logic [3:0]  reg_btn_event;

  regfile_mmio_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_mmio dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .bus           (bus),
    .SW            (sw),
    .BTN           (btn),
    .reg_sw        (reg_sw),
    .reg_btn_event (reg_btn_event)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            sel_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e, act;
      int            s;
      string         n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      case (s)
        0:       act = bus.data_readRegA;
        1:       act = bus.data_readRegB;
        2:       act = {16'h0, reg_sw};
        default: act = {28'h0, reg_btn_event};
      endcase
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input int wr, input logic [DW-1:0] wd,
                       input int ra, input int rb);
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = AW'(wr);
    bus.data_writeReg    = wd;
    bus.ctrl_readRegA    = AW'(ra);
    bus.ctrl_readRegB    = AW'(rb);
  endtask

  task automatic expect_val(input int sel, input logic [DW-1:0] e, input string n);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ctrl_reset_n = 1'b0;
    sw  = 16'hFFFF;
    btn = 4'hF;
    drive(1'b0, 0, '0, 0, 0);
    tick();
    tick();

    // Reset state: every address reads 0 on both ports, mapped outputs are 0.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 0, '0, i, 31 - i);
      expect_val(0, '0, $sformatf("reset_a_r%0d", i));
      expect_val(1, '0, $sformatf("reset_b_r%0d", 31 - i));
      if (i == 0) begin
        expect_val(2, '0, "reset_reg_sw");
        expect_val(3, '0, "reset_reg_btn_event");
      end
      tick();
    end

    sw  = 16'h0000;
    btn = 4'h0;
    tick();
    tick();
    ctrl_reset_n = 1'b1;
    tick();
    tick();

    // GP writes and register 0.
    drive(1'b1, 5, 32'hDEADBEEF, 5, 0);
`ifdef REGFILE_BYPASS_EN
    expect_val(0, 32'hDEADBEEF, "bypass_r5_same_cycle");
`else
    expect_val(0, 32'h0, "no_bypass_r5_same_cycle");
`endif
    tick();
    drive(1'b1, 0, 32'h1234, 5, 0);
    expect_val(0, 32'hDEADBEEF, "r5_after_write");
    expect_val(1, 32'h0, "r0_during_write");
    tick();
    drive(1'b1, 26, 32'hFFFF_FFFF, 0, 26);
    expect_val(0, 32'h0, "r0_after_write");
    expect_val(1, 32'h0, "r26_write_not_bypassed");
    tick();
    drive(1'b0, 0, '0, 26, 5);
    expect_val(0, 32'h0, "r26_write_ignored");
    expect_val(1, 32'hDEADBEEF, "r5_held");
    tick();

    // Switch mapping with two-edge latency.
    sw = 16'hA55A;
    tick();
    drive(1'b1, 27, 32'h0, 26, 27);
    expect_val(0, 32'h0, "r26_old_after_1_edge");
    expect_val(2, 32'h0, "reg_sw_old_after_1_edge");
    tick();
    drive(1'b0, 0, '0, 26, 27);
    expect_val(0, 32'h5A, "r26_switch_lo");
    expect_val(1, 32'hA5, "r27_switch_hi_write_ignored");
    expect_val(2, 32'hA55A, "reg_sw_synced");
    tick();

    // Button level and sticky event.
    btn = 4'h2;
    drive(1'b0, 0, '0, 28, 29);
    tick();
    tick();
    expect_val(0, 32'h2, "r28_level_after_2_edges");
    expect_val(1, 32'h0, "r29_not_yet_after_2_edges");
    tick();
    expect_val(1, 32'h2, "r29_event_after_3_edges");
    expect_val(3, 32'h2, "reg_btn_event_set");
    tick();
    tick();
    btn = 4'h0;
    tick();
    tick();
    expect_val(0, 32'h0, "r28_level_released");
    expect_val(1, 32'h2, "r29_sticky_after_release");
    tick();
    drive(1'b1, 29, 32'h2, 28, 29);
    expect_val(1, 32'h2, "r29_before_clear_commit");
    tick();
    drive(1'b0, 0, '0, 28, 29);
    expect_val(1, 32'h0, "r29_cleared");
    tick();

    // Collision: clear-all lands on the edge that detects BTN[0].
    btn = 4'h1;
    tick();
    tick();
    drive(1'b1, 29, 32'hF, 28, 29);
    expect_val(0, 32'h1, "r28_level_bit0");
    tick();
    drive(1'b0, 0, '0, 28, 29);
    expect_val(1, 32'h1, "r29_set_wins_collision");
    expect_val(3, 32'h1, "reg_btn_event_collision");
    tick();
    btn = 4'h0;

    // Bypass on a GP register.
    drive(1'b1, 7, 32'h11, 7, 7);
    tick();
    drive(1'b1, 7, 32'h55, 7, 5);
`ifdef REGFILE_BYPASS_EN
    expect_val(0, 32'h55, "bypass_r7_same_cycle");
`else
    expect_val(0, 32'h11, "no_bypass_r7_same_cycle");
`endif
    tick();
    drive(1'b0, 0, '0, 7, 5);
    expect_val(0, 32'h55, "r7_after_write");
    tick();

    // Reset mid-operation drops the pending write and clears everything asynchronously.
    drive(1'b1, 9, 32'hABC, 5, 26);
    ctrl_reset_n = 1'b0;
    expect_val(0, 32'h0, "r5_async_reset");
    expect_val(1, 32'h0, "r26_async_reset");
    expect_val(3, 32'h0, "reg_btn_event_async_reset");
    tick();
    drive(1'b0, 0, '0, 9, 7);
    ctrl_reset_n = 1'b1;
    tick();
    expect_val(0, 32'h0, "r9_write_discarded");
    expect_val(1, 32'h0, "r7_cleared_by_reset");
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
